ball_pair_scheduler: RTL and testbench

//  Per-frame scheduler that shares one collision-resolution unit among all balls on the table.
//  On each startOfFrame while rolling is enabled, it walks every unordered ball pair (a<b) in

---
 rtl/game_pkg.sv | 22 ++
 rtl/pair_index_counter.sv | 54 +++++
 rtl/ball_pair_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ball_pair_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and defaults for the ball pair scheduler
//
// Purpose: the scheduler state encoding, the default table size and the
// ball index type used by the scheduler and its pair counter.
// Ports: none (package).

package game_pkg;

  localparam int NUM_BALLS_DEFAULT = 8;
  localparam int IDX_W_DEFAULT     = $clog2(NUM_BALLS_DEFAULT);

  typedef logic [IDX_W_DEFAULT-1:0] ball_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/pair_index_counter.sv
// rtl/pair_index_counter.sv - walks every unordered ball pair (a<b) in fixed order
//
// Purpose: holds the current pair (a,b). A load restarts the walk at (0,1).
// An advance steps b, or moves to the next row (a+1, a+2) once b is at the
// last ball. last_o flags the final pair (NUM_BALLS-2, NUM_BALLS-1).
// Ports:
//   clk, resetN  clock, async active-low reset (pair returns to (0,0))
//   load_i       restart at (0,1)
//   advance_i    step to the next pair
//   idx_a_o      current a
//   idx_b_o      current b
//   last_o       current pair is the final one

module pair_index_counter #(
  parameter int NUM_BALLS = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] idx_a_o,
  output logic [IDX_W-1:0] idx_b_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] LAST_A = IDX_W'(NUM_BALLS - 2);
  localparam logic [IDX_W-1:0] LAST_B = IDX_W'(NUM_BALLS - 1);

  logic [IDX_W-1:0] a_q, b_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load_i) begin
      a_q <= '0;
      b_q <= IDX_W'(1);
    end else if (advance_i) begin
      if (b_q != LAST_B) begin
        b_q <= b_q + 1'b1;
      end else begin
        // New row: b starts just above the new a, i.e. old a + 2.
        a_q <= a_q + 1'b1;
        b_q <= a_q + IDX_W'(2);
      end
    end
  end

  assign idx_a_o = a_q;
  assign idx_b_o = b_q;
  assign last_o  = (a_q == LAST_A) && (b_q == LAST_B);

endmodule

// File: rtl/ball_pair_scheduler.sv
// rtl/ball_pair_scheduler.sv - per-frame sweep of ball pairs onto one shared resolver
//
// Purpose: on startOfFrame with rollEnable high, walks all pairs (a<b), issues
// each pair whose balls are both on the table via a valid/ready handshake and
// waits for resolverDone (bounded by TIMEOUT cycles) before moving on.
// Ports:
//   clk, resetN   clock, async active-low reset
//   startOfFrame  frame boundary pulse
//   rollEnable    sweeping allowed while high
//   ballActive    per-ball on-table mask
//   pairReady     resolver accepts the presented pair
//   resolverDone  resolver finished the current pair
//   clearFlags    clears overrun and timeoutErr
//   pairValid     pair presented on idxA/idxB
//   idxA, idxB    pair indices (idxA < idxB)
//   busy          sweep in progress
//   sweepDone     one-cycle pulse at normal sweep completion
//   overrun       sticky: frame pulse arrived while busy
//   timeoutErr    sticky: a pair was abandoned for lack of resolverDone

module ball_pair_scheduler #(
  parameter int NUM_BALLS = game_pkg::NUM_BALLS_DEFAULT,
  parameter int IDX_W     = $clog2(NUM_BALLS),
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 rollEnable,
  input  logic [NUM_BALLS-1:0] ballActive,
  input  logic                 pairReady,
  input  logic                 resolverDone,
  input  logic                 clearFlags,
  output logic                 pairValid,
  output logic [IDX_W-1:0]     idxA,
  output logic [IDX_W-1:0]     idxB,
  output logic                 busy,
  output logic                 sweepDone,
  output logic                 overrun,
  output logic                 timeoutErr
);

  import game_pkg::*;

  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  sched_state_t     state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             pair_valid_q, busy_q, sweep_done_q;
  logic             overrun_q, timeout_err_q;
  logic             cnt_load, cnt_adv, cnt_last;
  logic             pair_live, timed_out, sof_while_busy;

  pair_index_counter #(
    .NUM_BALLS (NUM_BALLS),
    .IDX_W     (IDX_W)
  ) u_pair_cnt (
    .clk       (clk),
    .resetN    (resetN),
    .load_i    (cnt_load),
    .advance_i (cnt_adv),
    .idx_a_o   (idxA),
    .idx_b_o   (idxB),
    .last_o    (cnt_last)
  );

  // Live sample: only consulted in SCAN, so changes during ISSUE/WAIT
  // cannot disturb a pair already committed.
  assign pair_live = ballActive[idxA] & ballActive[idxB];

  assign sof_while_busy = startOfFrame &&
                          ((state_q == ST_SCAN) || (state_q == ST_ISSUE) || (state_q == ST_WAIT));

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_load  = 1'b0;
    cnt_adv   = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startOfFrame && rollEnable) begin
          state_d  = ST_SCAN;
          cnt_load = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!rollEnable) begin
          state_d = ST_IDLE;
        end else if (pair_live) begin
          state_d = ST_ISSUE;
        end else if (cnt_last) begin
          state_d = ST_DONE;
        end else begin
          cnt_adv = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (pairReady) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        if (resolverDone || (timer_q == TMR_LAST)) begin
          // A done arriving on the final timer cycle still counts as done.
          timed_out = !resolverDone;
          // rollEnable is only honoured once the pair in flight is finished.
          if (!rollEnable) begin
            state_d = ST_IDLE;
          end else if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
            cnt_adv = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: begin
        // A frame pulse here is dropped without raising overrun.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      pair_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      // Outputs are decoded from the next state so they line up with state_q.
      pair_valid_q  <= (state_d == ST_ISSUE);
      busy_q        <= (state_d == ST_SCAN) || (state_d == ST_ISSUE) || (state_d == ST_WAIT);
      sweep_done_q  <= (state_d == ST_DONE);
      // Setting events take priority over clearFlags.
      overrun_q     <= sof_while_busy | (overrun_q & ~clearFlags);
      timeout_err_q <= timed_out | (timeout_err_q & ~clearFlags);
    end
  end

  assign pairValid  = pair_valid_q;
  assign busy       = busy_q;
  assign sweepDone  = sweep_done_q;
  assign overrun    = overrun_q;
  assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_ball_pair_scheduler.sv
// tb/tb_ball_pair_scheduler.sv - directed self-checking bench for ball_pair_scheduler

module tb_ball_pair_scheduler;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame, rollEnable, pairReady, resolverDone, clearFlags;
  logic [NB-1:0] ballActive;
  logic          pairValid, busy, sweepDone, overrun, timeoutErr;
  logic [2:0]    idxA, idxB;

  int total = 0;
  int bad   = 0;

  ball_pair_scheduler #(.NUM_BALLS(NB), .IDX_W(3), .TIMEOUT(64)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .rollEnable   (rollEnable),
    .ballActive   (ballActive),
    .pairReady    (pairReady),
    .resolverDone (resolverDone),
    .clearFlags   (clearFlags),
    .pairValid    (pairValid),
    .idxA         (idxA),
    .idxB         (idxB),
    .busy         (busy),
    .sweepDone    (sweepDone),
    .overrun      (overrun),
    .timeoutErr   (timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    chk("start_busy", busy, 1);
  endtask

  // Serves pairs with pairReady=1 and resolverDone two cycles after acceptance,
  // starting from pair (a0,b0). Expects sweepDone exp_len cycles from now.
  task automatic run_sweep(input int a0, input int b0, input logic [NB-1:0] mask,
                           input int exp_len, input int ovr_at, input bit sof_in_done);
    int  exp_a[$];
    int  exp_b[$];
    int  got  = 0;
    int  cyc  = 0;
    int  dly  = -1;
    bit  seen = 0;
    for (int a = 0; a < NB; a++)
      for (int b = a + 1; b < NB; b++)
        if ((a > a0 || (a == a0 && b >= b0)) && mask[a] && mask[b]) begin
          exp_a.push_back(a);
          exp_b.push_back(b);
        end
    pairReady = 1'b1;
    while (!seen && cyc < 400) begin
      step();
      cyc++;
      resolverDone = 1'b0;
      startOfFrame = 1'b0;
      if (dly > 0) dly--;
      if (dly == 0) begin
        resolverDone = 1'b1;
        dly = -1;
      end
      if (cyc == ovr_at) startOfFrame = 1'b1;
      if (pairValid) begin
        if (got < exp_a.size()) begin
          chk("pair_a", idxA, exp_a[got]);
          chk("pair_b", idxB, exp_b[got]);
        end
        got++;
        dly = 2;
      end
      if (sweepDone) begin
        seen = 1;
        chk("sweep_len", cyc, exp_len);
      end
    end
    chk("sweep_seen", seen, 1);
    chk("handshakes", got, exp_a.size());
    resolverDone = 1'b0;
    startOfFrame = sof_in_done;
    step();
    startOfFrame = 1'b0;
    chk("done_pulse_len", sweepDone, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", pairValid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    rollEnable   = 1'b0;
    ballActive   = '0;
    pairReady    = 1'b0;
    resolverDone = 1'b0;
    clearFlags   = 1'b0;
    step();
    step();
    chk("rst_valid", pairValid, 0);
    chk("rst_idxA", idxA, 0);
    chk("rst_idxB", idxB, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweepDone, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_tmo", timeoutErr, 0);
    resetN = 1'b1;
    step();

    // 1: full table, 28 pairs at 4 cycles each
    rollEnable = 1'b1;
    ballActive = 8'hFF;
    start_frame();
    run_sweep(0, 1, 8'hFF, 112, -1, 0);

    // 2: only balls 0 and 2; frame pulse in the DONE cycle is ignored
    ballActive = 8'b0000_0101;
    start_frame();
    run_sweep(0, 1, 8'b0000_0101, 31, -1, 1);
    step();
    chk("sof_done_busy", busy, 0);
    chk("sof_done_ovr", overrun, 0);

    // 3: pair held while pairReady is low
    ballActive = 8'hFF;
    pairReady  = 1'b0;
    start_frame();
    step();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", pairValid, 1);
      chk("hold_idxA", idxA, 0);
      chk("hold_idxB", idxB, 1);
      step();
    end

    // 4: resolverDone never comes for (0,1)
    pairReady = 1'b1;
    step();
    chk("wait_valid", pairValid, 0);
    repeat (63) step();
    chk("tmo_early", timeoutErr, 0);
    step();
    chk("tmo_set", timeoutErr, 1);
    chk("tmo_next_a", idxA, 0);
    chk("tmo_next_b", idxB, 2);
    chk("tmo_busy", busy, 1);
    run_sweep(0, 2, 8'hFF, 108, -1, 0);
    clearFlags = 1'b1;
    step();
    clearFlags = 1'b0;
    chk("tmo_clear", timeoutErr, 0);

    // 5: frame pulse mid-sweep
    start_frame();
    run_sweep(0, 1, 8'hFF, 112, 5, 0);
    chk("ovr_set", overrun, 1);
    clearFlags = 1'b1;
    step();
    clearFlags = 1'b0;
    chk("ovr_clear", overrun, 0);

    // 6: rollEnable dropped in WAIT
    pairReady = 1'b1;
    start_frame();
    step();
    chk("r6_issue", pairValid, 1);
    step();
    rollEnable = 1'b0;
    step();
    step();
    chk("r6_wait_busy", busy, 1);
    resolverDone = 1'b1;
    step();
    resolverDone = 1'b0;
    chk("r6_busy", busy, 0);
    chk("r6_done", sweepDone, 0);
    chk("r6_valid", pairValid, 0);
    step();
    chk("r6_done2", sweepDone, 0);

    // 6b: async reset while in ISSUE
    rollEnable = 1'b1;
    pairReady  = 1'b0;
    start_frame();
    step();
    chk("r7_issue", pairValid, 1);
    #2;
    resetN = 1'b0;
    #1;
    chk("r7_valid", pairValid, 0);
    chk("r7_busy", busy, 0);
    chk("r7_idxB", idxB, 0);
    @(negedge clk);
    resetN = 1'b1;
    step();
    chk("r7_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
